// File: rtl/obi_pkg.sv
// Shared OBI definitions: DMA FSM state type and bus constants.
package obi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } dma_state_e;

  localparam logic [3:0]  OBI_BE_FULL    = 4'hF;
  localparam int unsigned OBI_WORD_BYTES = 4;

endpackage

// File: rtl/obi_dma.sv
// obi_dma: single-channel word-copy engine with one OBI initiator port.
// Defining OBI_DMA_FILL_EN adds a pattern-fill mode (fill_i / fill_data_i).
module obi_dma
  import obi_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned BASE_ALIGN = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
`ifdef OBI_DMA_FILL_EN
  input  logic             fill_i,
  input  logic [31:0]      fill_data_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             dma_req_o,
  input  logic             dma_gnt_i,
  output logic [31:0]      dma_addr_o,
  output logic             dma_we_o,
  output logic [3:0]       dma_be_o,
  output logic [31:0]      dma_wdata_o,
  input  logic             dma_rvalid_i,
  input  logic [31:0]      dma_rdata_i
);

  localparam logic [31:0] STEP       = 32'(OBI_WORD_BYTES);
  localparam logic [31:0] ALIGN_MASK = 32'(BASE_ALIGN - 1);

  dma_state_e       state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [3:0]       be_q;
  logic             req_q;
  logic             we_q;
  logic             err_q;
  logic             fill_q;

  logic             fill_sel;
  logic [31:0]      fill_pat;
  logic             src_bad;
  logic             dst_bad;
  logic [31:0]      src_next;
  logic [31:0]      dst_next;
  logic             last_word;

`ifdef OBI_DMA_FILL_EN
  assign fill_sel = fill_i;
  assign fill_pat = fill_data_i;
`else
  assign fill_sel = 1'b0;
  assign fill_pat = '0;
`endif

  // Fill never reads the source, so its alignment is irrelevant there.
  assign src_bad   = ((src_addr_i & ALIGN_MASK) != '0) && !fill_sel;
  assign dst_bad   = (dst_addr_i & ALIGN_MASK) != '0;
  assign src_next  = src_q + STEP;
  assign dst_next  = dst_q + STEP;
  assign last_word = cnt_q == LEN_W'(1);

  // Bus outputs are registers loaded on state entry, so addr/be/wdata
  // naturally hold their last value whenever req is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      be_q   <= '0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            err_q  <= 1'b0;
            src_q  <= src_addr_i;
            dst_q  <= dst_addr_i;
            cnt_q  <= len_i;
            fill_q <= fill_sel;
            if (src_bad || dst_bad) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (len_i == '0) begin
              state <= DONE;
            end else if (fill_sel) begin
              data_q <= fill_pat;
              req_q  <= 1'b1;
              we_q   <= 1'b1;
              be_q   <= OBI_BE_FULL;
              addr_q <= dst_addr_i;
              state  <= WR_REQ;
            end else begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              be_q   <= OBI_BE_FULL;
              addr_q <= src_addr_i;
              state  <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (dma_gnt_i) begin
            req_q <= 1'b0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (dma_rvalid_i) begin
            data_q <= dma_rdata_i;
            req_q  <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= dst_q;
            state  <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (dma_gnt_i) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (dma_rvalid_i) begin
            src_q <= src_next;
            dst_q <= dst_next;
            cnt_q <= cnt_q - LEN_W'(1);
            if (last_word) begin
              state <= DONE;
            end else if (fill_q) begin
              req_q  <= 1'b1;
              we_q   <= 1'b1;
              addr_q <= dst_next;
              state  <= WR_REQ;
            end else begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= src_next;
              state  <= RD_REQ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          req_q <= 1'b0;
          we_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  assign err_o       = err_q;
  assign dma_req_o   = req_q;
  assign dma_we_o    = we_q;
  assign dma_addr_o  = addr_q;
  assign dma_be_o    = be_q;
  assign dma_wdata_o = data_q;

endmodule

// File: tb/tb_obi_dma.sv
// Directed bench for obi_dma: copy, backpressure, edge-case starts, reset abort,
// and (with OBI_DMA_FILL_EN) pattern fill, against an OBI responder model.
module tb_obi_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        fill = 1'b0;
  logic [31:0] fdata = '0;
  logic        busy, done, err;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt = 1'b0;
  logic        rv_resp = 1'b0;
  logic        late_rv = 1'b0;
  logic        rvalid;
  logic [31:0] rdata = '0;

  int checks = 0;
  int failures = 0;

  // responder state (written only by the responder process)
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  int          stalled = 0;
  int          stall_cfg = 0;
  int          req_cycles = 0;
  logic [31:0] rd_addr[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  assign rvalid = rv_resp | late_rv;

  always #5 clk = ~clk;

  obi_dma #(.LEN_W(16), .BASE_ALIGN(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .src_addr_i  (src),
    .dst_addr_i  (dst),
    .len_i       (len),
`ifdef OBI_DMA_FILL_EN
    .fill_i      (fill),
    .fill_data_i (fdata),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .dma_req_o   (req),
    .dma_gnt_i   (gnt),
    .dma_addr_o  (addr),
    .dma_we_o    (we),
    .dma_be_o    (be),
    .dma_wdata_o (wdata),
    .dma_rvalid_i(rvalid),
    .dma_rdata_i (rdata)
  );

  // Responder: grant in the request cycle (after stall_cfg refusals), rvalid the
  // cycle after. Read data is 0xC0DE_0000 | addr[15:0].
  always @(negedge clk) begin
    rv_resp <= pend;
    rdata   <= pend_data;
    pend    <= 1'b0;
    if (req) begin
      req_cycles <= req_cycles + 1;
      if (stalled < stall_cfg) begin
        gnt     <= 1'b0;
        stalled <= stalled + 1;
      end else begin
        gnt     <= 1'b1;
        stalled <= 0;
        pend    <= 1'b1;
        if (we) begin
          wr_addr.push_back(addr);
          wr_data.push_back(wdata);
        end else begin
          rd_addr.push_back(addr);
          pend_data <= {16'hC0DE, addr[15:0]};
        end
      end
    end else begin
      gnt <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Leaves the bench #1 into cycle 1 (cycle 0 is the one with start_i high).
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input logic f, input logic [31:0] fd);
    src = s; dst = d; len = n; fill = f; fdata = fd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle number in which done is high, or -1 on timeout.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  initial begin
    int c;
    int nr, nw, nq;
    logic seen;

    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_be", be, 4'h0);

    // copy of 3 words
    nr = rd_addr.size(); nw = wr_addr.size();
    start_xfer(32'h8000_0000, 32'h8000_0400, 16'd3, 1'b0, '0);
    check("copy_busy", busy, 1);
    wait_done(1, c);
    check("copy_cycle", 32'(c), 32'd13);
    check("copy_err", err, 0);
    tick();
    check("copy_nrd", 32'(rd_addr.size() - nr), 32'd3);
    check("copy_nwr", 32'(wr_addr.size() - nw), 32'd3);
    if (rd_addr.size() - nr == 3 && wr_addr.size() - nw == 3) begin
      check("copy_rd0", rd_addr[nr],   32'h8000_0000);
      check("copy_rd1", rd_addr[nr+1], 32'h8000_0004);
      check("copy_rd2", rd_addr[nr+2], 32'h8000_0008);
      check("copy_wa0", wr_addr[nw],   32'h8000_0400);
      check("copy_wa1", wr_addr[nw+1], 32'h8000_0404);
      check("copy_wa2", wr_addr[nw+2], 32'h8000_0408);
      check("copy_wd0", wr_data[nw],   32'hC0DE_0000);
      check("copy_wd1", wr_data[nw+1], 32'hC0DE_0004);
      check("copy_wd2", wr_data[nw+2], 32'hC0DE_0008);
    end
    check("idle_busy", busy, 0);
    check("idle_we", we, 0);
    check("idle_addr_hold", addr, 32'h8000_0408);
    check("idle_wdata_hold", wdata, 32'hC0DE_0008);
    check("idle_be_hold", be, 4'hF);

    // backpressure: first read refused for 5 cycles
    stall_cfg = 5;
    start_xfer(32'h8000_0000, 32'h8000_0800, 16'd3, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      check("bp_req", req, 1);
      check("bp_we", we, 0);
      check("bp_addr", addr, 32'h8000_0000);
      tick();
    end
    stall_cfg = 0;
    wait_done(6, c);
    check("bp_cycle", 32'(c), 32'd18);
    tick();

    // len = 0
    nq = req_cycles;
    start_xfer(32'h8000_0000, 32'h8000_0000, 16'd0, 1'b0, '0);
    wait_done(1, c);
    check("len0_cycle", 32'(c), 32'd1);
    check("len0_err", err, 0);
    tick();
    check("len0_noreq", 32'(req_cycles - nq), 32'd0);

    // misaligned source
    nq = req_cycles;
    start_xfer(32'h8000_0002, 32'h8000_0400, 16'd2, 1'b0, '0);
    wait_done(1, c);
    check("mis_cycle", 32'(c), 32'd1);
    check("mis_err", err, 1);
    tick(); tick(); tick();
    check("mis_err_sticky", err, 1);
    check("mis_busy", busy, 0);
    check("mis_noreq", 32'(req_cycles - nq), 32'd0);
    start_xfer(32'h8000_0000, 32'h8000_0000, 16'd0, 1'b0, '0);
    check("err_cleared", err, 0);
    wait_done(1, c);
    tick();

    // start while busy is ignored
    nw = wr_addr.size();
    start_xfer(32'h8000_0000, 32'h8000_0C00, 16'd2, 1'b0, '0);
    tick();
    src = 32'h8000_0002; dst = 32'h8000_0100; len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, c);
    check("busy_start_cycle", 32'(c), 32'd9);
    check("busy_start_err", err, 0);
    tick();
    check("busy_start_nwr", 32'(wr_addr.size() - nw), 32'd2);
    if (wr_addr.size() - nw == 2) begin
      check("busy_start_wa0", wr_addr[nw],   32'h8000_0C00);
      check("busy_start_wa1", wr_addr[nw+1], 32'h8000_0C04);
    end

    // reset during WR_WAIT, then a late rvalid
    nw = wr_addr.size();
    start_xfer(32'h8000_0000, 32'h8000_0C00, 16'd2, 1'b0, '0);
    c = 0;
    while (wr_addr.size() == nw && c < 50) begin
      tick();
      c++;
    end
    check("rst_reach_wrwait", 32'(wr_addr.size() - nw), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_req", req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr", addr, 32'h0);
    nr = rd_addr.size();
    late_rv = 1'b1;
    tick();
    late_rv = 1'b0;
    seen = done;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | done | busy;
    end
    check("late_rv_quiet", seen, 0);
    check("late_rv_wdata", wdata, 32'h0);
    check("late_rv_nrd", 32'(rd_addr.size() - nr), 32'd0);

`ifdef OBI_DMA_FILL_EN
    // fill 4 words; misaligned src must not matter
    nr = rd_addr.size(); nw = wr_addr.size();
    start_xfer(32'h8000_0001, 32'h8000_0000, 16'd4, 1'b1, 32'hDEAD_BEEF);
    wait_done(1, c);
    check("fill_cycle", 32'(c), 32'd9);
    check("fill_err", err, 0);
    tick();
    check("fill_nrd", 32'(rd_addr.size() - nr), 32'd0);
    check("fill_nwr", 32'(wr_addr.size() - nw), 32'd4);
    if (wr_addr.size() - nw == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("fill_wa", wr_addr[nw+i], 32'h8000_0000 + 32'(4 * i));
        check("fill_wd", wr_data[nw+i], 32'hDEAD_BEEF);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_dma.md
OBI_DMA -- requirements
Module: obi_dma

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, giving the width of the word-count input.
REQ-002 The block SHALL have parameter BASE_ALIGN, default 4, giving the required byte alignment of the src and dst addresses.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: one-cycle transfer launch.
REQ-006 The block SHALL have port src_addr_i, input, 32 bits: source byte address.
REQ-007 The block SHALL have port dst_addr_i, input, 32 bits: destination byte address.
REQ-008 The block SHALL have port len_i, input, LEN_W bits: number of 32-bit words to copy.
REQ-009 The block SHALL have port busy_o, output, 1 bit: transfer in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port err_o, output, 1 bit: sticky error flag, cleared by the next accepted start.
REQ-012 The block SHALL have OBI initiator ports dma_req_o (out 1), dma_gnt_i (in 1), dma_addr_o (out 32), dma_we_o (out 1), dma_be_o (out 4), dma_wdata_o (out 32), dma_rvalid_i (in 1) and dma_rdata_i (in 32).

Function
REQ-013 The FSM states SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DONE.
REQ-014 In IDLE, start_i=1 SHALL latch src, dst and len and move the FSM to RD_REQ on the next edge.
  - Exception: len_i=0 goes to DONE.
  - Exception: src_addr_i[1:0]!=0 or dst_addr_i[1:0]!=0 goes to DONE with err_o set.
REQ-015 start_i SHALL be ignored in every state except IDLE.
REQ-016 In RD_REQ the block SHALL drive dma_req_o=1, dma_we_o=0, dma_be_o=4'hF and dma_addr_o=current src, holding all of them stable until dma_gnt_i=1, then go to RD_WAIT.
REQ-017 In RD_WAIT the block SHALL drive dma_req_o=0.
  - On dma_rvalid_i=1, dma_rdata_i is captured into a 32-bit data register and the FSM goes to WR_REQ.
REQ-018 In WR_REQ the block SHALL drive dma_req_o=1, dma_we_o=1, dma_be_o=4'hF, dma_addr_o=current dst and dma_wdata_o=data register, all held stable until dma_gnt_i, then go to WR_WAIT.
REQ-019 In WR_WAIT, dma_rvalid_i=1 SHALL do all of the following:
  - add 4 to src and dst, modulo 2^32 (wrap silently);
  - decrement the remaining count;
  - go to RD_REQ if the count is nonzero, else to DONE.
REQ-020 At most one OBI transaction SHALL be outstanding, and dma_rvalid_i outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-021 DONE SHALL last exactly one cycle, asserting done_o=1, then return to IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 With a same-cycle-grant, next-cycle-rvalid responder, each word SHALL take exactly 4 cycles, so N words give done_o 4N+1 cycles after the start_i edge.
REQ-024 When dma_req_o=0, dma_we_o SHALL be 0 and dma_addr_o, dma_wdata_o and dma_be_o SHALL hold their last values.

Reset
REQ-025 rst_i=1 SHALL force, at the next edge:
  - state to IDLE;
  - busy_o, done_o, err_o, dma_req_o and dma_we_o to 0;
  - dma_addr_o, dma_wdata_o, the address registers and the count to 0;
  - dma_be_o to 4'h0.
REQ-026 A reset mid-transfer SHALL abort immediately with no done_o pulse, and an rvalid arriving after reset SHALL be ignored.

Configuration
REQ-027 Macro OBI_DMA_FILL_EN SHALL, when defined, add two input ports:
  - fill_i (1 bit);
  - fill_data_i (32 bits).
REQ-028 With OBI_DMA_FILL_EN defined, a start with fill_i=1 SHALL latch fill_data_i, skip RD_REQ/RD_WAIT entirely, and write that pattern to dst for len words.
  - Cost is 2 cycles per word.
  - The src alignment check is not applied.
REQ-029 Without OBI_DMA_FILL_EN, those ports and the fill path SHALL be absent, and behaviour SHALL be copy-only as above.

Structure
REQ-030 A shared package obi_pkg SHALL hold:
  - the FSM state enum type dma_state_e;
  - the constants OBI_BE_FULL=4'hF and OBI_WORD_BYTES=4.
REQ-031 The block SHALL be one module with no sub-modules; the FSM, address/count registers and data register are all inline.

Verification
REQ-032 Copy test: src=0x8000_0000, dst=0x8000_0400, len=3, ideal responder.
  - Expect 3 reads at 0x..000/004/008 then writes at 0x..400/404/408.
  - Expect the data to match.
  - Expect done_o at cycle 13.
REQ-033 Backpressure test: hold dma_gnt_i=0 for 5 cycles on the first read.
  - Expect dma_addr_o and dma_req_o stable throughout.
  - Expect the completion to slip by exactly 5 cycles.
REQ-034 Edge-case starts:
  - len=0: done_o in the next cycle, no dma_req_o ever, err_o=0.
  - src=0x8000_0002: done_o with err_o=1, no OBI traffic.
REQ-035 Robustness test:
  - Pulse start_i while busy: expect it ignored.
  - Assert rst_i during WR_WAIT: expect dma_req_o=0, busy_o=0, no done_o, and a late rvalid ignored.
REQ-036 Fill test, with OBI_DMA_FILL_EN defined: fill_i=1, fill_data_i=0xDEAD_BEEF, dst=0x8000_0000, len=4.
  - Expect 4 writes of 0xDEAD_BEEF and zero reads.
  - Expect done_o at cycle 9.
